// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage RV32I pipeline.
// Tracks in-flight destinations in an X/M/W shadow pipeline and drives bypass, stall and flush controls.
module hazard_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_d,
    input  logic             pcsel_x,
    output logic [1:0]       byp_a_x,
    output logic [1:0]       byp_b_x,
    output logic             byp_a_d,
    output logic             byp_b_d,
    output logic             stall_fd,
    output logic             bubble_x,
    output logic             flush_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] BYP_NONE = 2'b00;
    localparam logic [1:0] BYP_MX   = 2'b01;
    localparam logic [1:0] BYP_WX   = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } slot_t;

    // Register-usage decode; wr_en is cleared for rd == x0 so x0 can never match.
    function automatic slot_t decode(input logic [31:0] inst);
        slot_t s;
        logic  wr;
        s     = '0;
        wr    = 1'b0;
        s.rd  = inst[11:7];
        s.rs1 = inst[19:15];
        s.rs2 = inst[24:20];
        case (inst[6:0])
            OP_RCC: begin
                wr         = 1'b1;
                s.rs1_used = 1'b1;
                s.rs2_used = 1'b1;
            end
            OP_MCC, OP_JALR: begin
                wr         = 1'b1;
                s.rs1_used = 1'b1;
            end
            OP_LCC: begin
                wr         = 1'b1;
                s.is_load  = 1'b1;
                s.rs1_used = 1'b1;
            end
            OP_SCC, OP_BCC: begin
                s.rs1_used = 1'b1;
                s.rs2_used = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                wr = 1'b1;
            end
            default: begin
                wr = 1'b0;
            end
        endcase
        s.wr_en = wr && (s.rd != 5'd0);
        return s;
    endfunction

    slot_t nop_slot;
    slot_t dec_d;
    slot_t x_q, m_q, w_q;
    slot_t x_d;
    logic  ld_use;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign nop_slot = decode(NOP_INST);

    // Hazard detection and control outputs; all forced low while reset is held.
    always_comb begin
        dec_d       = decode(inst_d);
        byp_a_x     = BYP_NONE;
        byp_b_x     = BYP_NONE;
        byp_a_d     = 1'b0;
        byp_b_d     = 1'b0;
        ld_use      = 1'b0;
        stall_fd    = 1'b0;
        bubble_x    = 1'b0;
        flush_d     = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        x_d         = dec_d;

        if (!reset) begin
            if (m_q.wr_en && x_q.rs1_used && (m_q.rd == x_q.rs1)) begin
                byp_a_x = BYP_MX;
            end else if (w_q.wr_en && x_q.rs1_used && (w_q.rd == x_q.rs1)) begin
                byp_a_x = BYP_WX;
            end
            if (m_q.wr_en && x_q.rs2_used && (m_q.rd == x_q.rs2)) begin
                byp_b_x = BYP_MX;
            end else if (w_q.wr_en && x_q.rs2_used && (w_q.rd == x_q.rs2)) begin
                byp_b_x = BYP_WX;
            end

            byp_a_d = w_q.wr_en && dec_d.rs1_used && (w_q.rd == dec_d.rs1);
            byp_b_d = w_q.wr_en && dec_d.rs2_used && (w_q.rd == dec_d.rs2);

            ld_use = x_q.is_load && x_q.wr_en &&
                     ((dec_d.rs1_used && (x_q.rd == dec_d.rs1)) ||
                      (dec_d.rs2_used && (x_q.rd == dec_d.rs2)));

            // A redirect kills the stalled instruction, so the flush wins.
            flush_d  = pcsel_x;
            bubble_x = pcsel_x || ld_use;
            stall_fd = ld_use && !pcsel_x;
        end

        if (bubble_x) begin
            x_d = nop_slot;
        end
        if (stall_fd && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= nop_slot;
            m_q         <= nop_slot;
            w_q         <= nop_slot;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            x_q         <= x_d;
            m_q         <= x_q;
            w_q         <= m_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Source fields of older slots and non-register instruction bits carry no hazard information.
    logic unused_bits;
    assign unused_bits = ^{inst_d[31:25], inst_d[14:12],
                           m_q.is_load, m_q.rs1, m_q.rs2, m_q.rs1_used, m_q.rs2_used,
                           w_q.is_load, w_q.rs1, w_q.rs2, w_q.rs1_used, w_q.rs2_used};

endmodule
